// File: rtl/sop_programlanabilir.sv
// Programmable N-input sum-of-products: a 2^N_IN-bit minterm table loaded
// serially, evaluated with a registered output, and scanned to count its on-set.
module sop_programlanabilir #(
   parameter int N_IN = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_valid,
   input  logic            load_bit,
   output logic            load_ready,
   output logic            load_done,
   input  logic            reload,
   input  logic            in_valid,
   input  logic [N_IN-1:0] in_vec,
   output logic            out_valid,
   output logic            x,
   input  logic            scan_start,
   output logic            scan_busy,
   output logic            scan_done,
   output logic [N_IN:0]   ones_count
);

   localparam int TBL = 1 << N_IN;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_RUN  = 2'd1,
      ST_SCAN = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [TBL-1:0]    tbl_q, tbl_d;
   logic [N_IN-1:0]   load_ptr_q, load_ptr_d;
   logic [N_IN-1:0]   scan_idx_q, scan_idx_d;
   logic [N_IN:0]     acc_q, acc_d;
   logic [N_IN:0]     ones_q, ones_d;
   logic              load_done_q, load_done_d;
   logic              out_valid_q, out_valid_d;
   logic              x_q, x_d;
   logic              scan_done_q, scan_done_d;

   logic              load_accept;
   logic              load_last;
   logic              scan_last;
   logic              run_reload;
   logic              run_scan;
   logic              run_eval;
   logic [N_IN:0]     scan_bit_ext;

   localparam logic [N_IN-1:0] IDX_ONE  = {{(N_IN-1){1'b0}}, 1'b1};
   localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

   assign load_accept  = (state_q == ST_LOAD) && load_valid;
   assign load_last    = (load_ptr_q == IDX_LAST);
   assign scan_last    = (scan_idx_q == IDX_LAST);
   // reload has priority over scan_start; evaluation is served either way
   assign run_reload   = (state_q == ST_RUN) && reload;
   assign run_scan     = (state_q == ST_RUN) && scan_start && !reload;
   assign run_eval     = (state_q == ST_RUN) && in_valid;
   assign scan_bit_ext = {{N_IN{1'b0}}, tbl_q[scan_idx_q]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_LOAD: begin
            if (load_accept && load_last) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (run_reload) begin
               state_d = ST_LOAD;
            end else if (run_scan) begin
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (scan_last) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   always_comb begin
      load_ready = (state_q == ST_LOAD);
      scan_busy  = (state_q == ST_SCAN);
   end

   always_comb begin
      tbl_d       = tbl_q;
      load_ptr_d  = load_ptr_q;
      scan_idx_d  = scan_idx_q;
      acc_d       = acc_q;
      ones_d      = ones_q;
      load_done_d = 1'b0;
      scan_done_d = 1'b0;
      out_valid_d = 1'b0;
      x_d         = x_q;

      if (load_accept) begin
         tbl_d[load_ptr_q] = load_bit;
         if (load_last) begin
            load_ptr_d  = '0;
            load_done_d = 1'b1;
         end else begin
            load_ptr_d  = load_ptr_q + IDX_ONE;
         end
      end

      if (run_eval) begin
         out_valid_d = 1'b1;
         x_d         = tbl_q[in_vec];
      end

      if (run_reload) begin
         load_ptr_d = '0;
      end

      if (run_scan) begin
         scan_idx_d = '0;
         acc_d      = '0;
      end

      // final index is folded straight into the published count
      if (state_q == ST_SCAN) begin
         acc_d      = acc_q + scan_bit_ext;
         scan_idx_d = scan_idx_q + IDX_ONE;
         if (scan_last) begin
            ones_d      = acc_q + scan_bit_ext;
            scan_done_d = 1'b1;
            scan_idx_d  = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tbl_q       <= '0;
         load_ptr_q  <= '0;
         scan_idx_q  <= '0;
         acc_q       <= '0;
         ones_q      <= '0;
         load_done_q <= 1'b0;
         scan_done_q <= 1'b0;
         out_valid_q <= 1'b0;
         x_q         <= 1'b0;
      end else begin
         tbl_q       <= tbl_d;
         load_ptr_q  <= load_ptr_d;
         scan_idx_q  <= scan_idx_d;
         acc_q       <= acc_d;
         ones_q      <= ones_d;
         load_done_q <= load_done_d;
         scan_done_q <= scan_done_d;
         out_valid_q <= out_valid_d;
         x_q         <= x_d;
      end
   end

   assign load_done  = load_done_q;
   assign scan_done  = scan_done_q;
   assign out_valid  = out_valid_q;
   assign x          = x_q;
   assign ones_count = ones_q;

endmodule

// File: tb/tb_sop_programlanabilir.sv
// Scoreboard bench for sop_programlanabilir (N_IN=4): directed scenarios plus
// randomized traffic against a behavioural table model.
module tb_sop_programlanabilir;

   localparam int N = 4;
   localparam int T = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         load_valid;
   logic         load_bit;
   logic         load_ready;
   logic         load_done;
   logic         reload;
   logic         in_valid;
   logic [N-1:0] in_vec;
   logic         out_valid;
   logic         x;
   logic         scan_start;
   logic         scan_busy;
   logic         scan_done;
   logic [N:0]   ones_count;

   sop_programlanabilir #(.N_IN(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_bit   (load_bit),
      .load_ready (load_ready),
      .load_done  (load_done),
      .reload     (reload),
      .in_valid   (in_valid),
      .in_vec     (in_vec),
      .out_valid  (out_valid),
      .x          (x),
      .scan_start (scan_start),
      .scan_busy  (scan_busy),
      .scan_done  (scan_done),
      .ones_count (ones_count)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // behavioural model: mode 0=LOAD 1=RUN 2=SCAN
   bit ref_tbl [T];
   int mode      = 0;
   int ptr       = 0;
   int scan_left = 0;
   int exp_ones  = 0;
   bit exp_ld    = 0;
   bit exp_sd    = 0;
   bit x_hold    = 0;
   bit mon_en    = 0;
   bit sb_q [$];

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int count_ones();
      int s = 0;
      for (int i = 0; i < T; i++) s += ref_tbl[i];
      return s;
   endfunction

   // Apply the effect of the inputs sampled at the edge that just occurred.
   task automatic model_update();
      exp_ld = 0;
      exp_sd = 0;
      if (rst) begin
         mode = 0;
         ptr = 0;
         scan_left = 0;
         exp_ones = 0;
         x_hold = 0;
         for (int i = 0; i < T; i++) ref_tbl[i] = 0;
         sb_q.delete();
      end else begin
         case (mode)
            0: if (load_valid) begin
                  ref_tbl[ptr] = load_bit;
                  if (ptr == T - 1) begin
                     ptr = 0;
                     mode = 1;
                     exp_ld = 1;
                  end else begin
                     ptr++;
                  end
               end
            1: begin
                  if (in_valid) sb_q.push_back(ref_tbl[in_vec]);
                  if (reload) begin
                     mode = 0;
                     ptr = 0;
                  end else if (scan_start) begin
                     mode = 2;
                     scan_left = T;
                  end
               end
            default: begin
                  scan_left--;
                  if (scan_left == 0) begin
                     exp_ones = count_ones();
                     exp_sd = 1;
                     mode = 1;
                  end
               end
         endcase
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk("load_ready", int'(load_ready), int'(mode == 0));
         chk("scan_busy", int'(scan_busy), int'(mode == 2));
         chk("load_done", int'(load_done), int'(exp_ld));
         chk("scan_done", int'(scan_done), int'(exp_sd));
         chk("ones_count", int'(ones_count), exp_ones);
         if (out_valid) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_out_valid", 1, 0);
            end else begin
               bit e;
               e = sb_q.pop_front();
               chk("x_eval", int'(x), int'(e));
               x_hold = e;
            end
         end else begin
            chk("x_hold", int'(x), int'(x_hold));
         end
      end
   end

   task automatic load_word(input logic [15:0] v, input bit gaps);
      for (int i = 0; i < T; i++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            load_valid = 0;
            load_bit   = 1'($urandom);
            in_valid   = 1'($urandom);
            in_vec     = 4'($urandom);
            tick();
         end
         load_valid = 1;
         load_bit   = v[i];
         in_valid   = 1'($urandom);
         in_vec     = 4'($urandom);
         tick();
      end
      load_valid = 0;
      in_valid   = 0;
   endtask

   task automatic do_reload();
      reload = 1;
      tick();
      reload = 0;
   endtask

   task automatic do_scan(input int exp_cnt);
      scan_start = 1;
      tick();
      scan_start = 0;
      chk("scan_busy_entry", int'(scan_busy), 1);
      for (int i = 0; i < T; i++) begin
         in_valid = 1'($urandom);
         in_vec   = 4'($urandom);
         tick();
      end
      in_valid = 0;
      chk("scan_done_end", int'(scan_done), 1);
      chk("scan_count", int'(ones_count), exp_cnt);
      chk("scan_busy_end", int'(scan_busy), 0);
   endtask

   initial begin
      logic [15:0] pat;
      pat = 16'hC4F4;
      rst = 1; load_valid = 0; load_bit = 0; reload = 0;
      in_valid = 0; in_vec = 0; scan_start = 0;
      tick();
      mon_en = 1;
      tick();
      rst = 0;
      chk("rst_load_ready", int'(load_ready), 1);
      chk("rst_ones", int'(ones_count), 0);

      load_word(pat, 1);
      chk("c4f4_load_done", int'(load_done), 1);
      chk("c4f4_load_ready", int'(load_ready), 0);

      for (int v = 0; v < T; v++) begin
         in_valid = 1;
         in_vec   = 4'(v);
         tick();
         chk("sweep_valid", int'(out_valid), 1);
         chk("sweep_x", int'(x), int'(pat[v]));
      end
      in_valid = 0;
      tick();
      chk("sweep_end_valid", int'(out_valid), 0);

      do_scan(8);

      reload = 1; scan_start = 1; in_valid = 1; in_vec = 4'd2;
      tick();
      reload = 0; scan_start = 0; in_valid = 0;
      chk("simul_x", int'(x), 1);
      chk("simul_load_ready", int'(load_ready), 1);
      chk("simul_no_scan", int'(scan_busy), 0);

      load_word(16'hFFFF, 1);
      do_scan(16);
      do_reload();
      load_word(16'h0000, 0);
      do_scan(0);

      do_reload();
      load_word(pat, 0);
      chk("fullrate_load_done", int'(load_done), 1);
      do_scan(8);

      scan_start = 1;
      tick();
      scan_start = 0;
      repeat (5) tick();
      rst = 1;
      tick();
      tick();
      rst = 0;
      chk("midscan_rst_ready", int'(load_ready), 1);
      chk("midscan_rst_busy", int'(scan_busy), 0);
      chk("midscan_rst_ones", int'(ones_count), 0);
      chk("midscan_rst_x", int'(x), 0);
      chk("midscan_rst_ov", int'(out_valid), 0);

      for (int c = 0; c < 1500; c++) begin
         rst        = ($urandom_range(0, 299) == 0);
         load_valid = ($urandom_range(0, 3) != 0);
         load_bit   = 1'($urandom);
         in_valid   = 1'($urandom);
         in_vec     = 4'($urandom);
         scan_start = ($urandom_range(0, 19) == 0);
         reload     = ($urandom_range(0, 39) == 0);
         tick();
      end
      rst = 0; load_valid = 0; in_valid = 0; scan_start = 0; reload = 0;
      repeat (T + 2) tick();
      chk("sb_drained", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
